// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub.
// The producer of operands and consumer of results is the master side.
interface pipelined_addsub_if #(
   parameter int unsigned WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             c_out;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, a, b, c_in, sub, out_ready,
      input  in_ready, out_valid, sum, c_out, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, c_in, sub, out_ready,
      output in_ready, out_valid, sum, c_out, ovf, zero
   );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: one SEG-bit ripple segment per stage,
// carries registered between stages, operands skewed in and sum segments delayed out.
module pipelined_addsub #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SEG   = 4
) (
   input logic               clk,
   input logic               rst_n,
   pipelined_addsub_if.slave bus
);
   localparam int unsigned STAGES = WIDTH / SEG;
   localparam int unsigned LAST   = STAGES - 1;

   logic             en;
   logic [WIDTH-1:0] b_eff;
   logic             cin0;
   logic             ovf_q;
   logic             zero_q;

   // Whole pipe advances together; a stalled output freezes every stage.
   assign en           = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = en;
   assign b_eff        = bus.sub ? ~bus.b : bus.b;
   assign cin0         = bus.sub | bus.c_in;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int unsigned LoW = (k + 1) * SEG;

      logic [SEG-1:0] seg_a;
      logic [SEG-1:0] seg_b;
      logic           cin;
      logic           vin;
      logic [SEG:0]   seg_sum;
      logic [LoW-1:0] lo_d;
      logic           valid_q;
      logic           cy_q;
      logic [LoW-1:0] lo_q;

      if (k == 0) begin : g_first
         assign seg_a = bus.a[SEG-1:0];
         assign seg_b = b_eff[SEG-1:0];
         assign cin   = cin0;
         assign vin   = bus.in_valid;
         assign lo_d  = seg_sum[SEG-1:0];
      end else begin : g_next
         assign seg_a = g_stage[k-1].g_skew.a_hi_q[SEG-1:0];
         assign seg_b = g_stage[k-1].g_skew.b_hi_q[SEG-1:0];
         assign cin   = g_stage[k-1].cy_q;
         assign vin   = g_stage[k-1].valid_q;
         assign lo_d  = {seg_sum[SEG-1:0], g_stage[k-1].lo_q};
      end

      assign seg_sum = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG{1'b0}}, cin};

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_q <= 1'b0;
            cy_q    <= 1'b0;
            lo_q    <= '0;
         end else if (en) begin
            valid_q <= vin;
            cy_q    <= seg_sum[SEG];
            lo_q    <= lo_d;
         end
      end

      // Operand bits not yet consumed ride along until their stage comes up.
      if (k < STAGES - 1) begin : g_skew
         localparam int unsigned HiW = WIDTH - LoW;

         logic [HiW-1:0] a_hi_d;
         logic [HiW-1:0] b_hi_d;
         logic [HiW-1:0] a_hi_q;
         logic [HiW-1:0] b_hi_q;

         if (k == 0) begin : g_src_in
            assign a_hi_d = bus.a[WIDTH-1:SEG];
            assign b_hi_d = b_eff[WIDTH-1:SEG];
         end else begin : g_src_prev
            assign a_hi_d = g_stage[k-1].g_skew.a_hi_q[HiW+SEG-1:SEG];
            assign b_hi_d = g_stage[k-1].g_skew.b_hi_q[HiW+SEG-1:SEG];
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_hi_q <= '0;
               b_hi_q <= '0;
            end else if (en) begin
               a_hi_q <= a_hi_d;
               b_hi_q <= b_hi_d;
            end
         end
      end
   end

   // Carry into the MSB is recovered as a ^ b ^ s at that bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (en) begin
         ovf_q  <= g_stage[LAST].seg_a[SEG-1] ^ g_stage[LAST].seg_b[SEG-1] ^
                   g_stage[LAST].seg_sum[SEG-1] ^ g_stage[LAST].seg_sum[SEG];
         zero_q <= (g_stage[LAST].lo_d == '0);
      end
   end

   assign bus.out_valid = g_stage[LAST].valid_q;
   assign bus.sum       = g_stage[LAST].lo_q;
   assign bus.c_out     = g_stage[LAST].cy_q;
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;
endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined two's-complement adder/subtractor built from SEG-bit ripple segments, one segment per pipeline stage.
- The carry registers between stages, so Fmax is set by a SEG-bit ripple rather than a WIDTH-bit ripple.
- Valid/ready handshake on both sides; feeds the ALU result mux and flag logic.
- Accepts one operation per cycle when not stalled.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of SEG.
- SEG, 4, bits per pipeline stage; STAGES = WIDTH/SEG (STAGES >= 1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set present.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in; used in add mode only.
- sub  input  1  0 = A+B+c_in; 1 = A-B, computed as A+~B+1 (c_in ignored).
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- c_out  output  1  carry out of MSB; in sub mode 1 = no borrow.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  sum == 0.

Behaviour:
- Global advance: en = !out_valid || out_ready; in_ready = en (combinational).
- Transfer in on in_valid && in_ready; transfer out on out_valid && out_ready.
- When en = 0, every pipeline register holds, including valid bits and skewed operands. Nothing is dropped or duplicated.
- Stage k (0..STAGES-1) adds segment k of A and of B' (B' = sub ? ~b : b) with the carry registered by stage k-1.
  - Stage 0 carry-in = sub ? 1 : c_in.
  - Higher operand segments are skew-registered so segment k enters stage k exactly k cycles after capture.
  - Completed low segments of the sum are delay-registered so all segments align at the output.
- Latency: a transfer-in at cycle t, with no stalls, gives out_valid = 1 with the result at cycle t+STAGES.
- Throughput is 1/cycle. Bubbles (in_valid = 0 while en = 1) travel down the pipe as invalid slots.
- All outputs (sum, c_out, ovf, zero, out_valid) are registered; none depends combinationally on a, b, or in_valid.
- ovf and zero are computed in the final stage: ovf from the MSB segment's internal carries, zero over the full aligned sum.
- Arithmetic is modulo 2^WIDTH. c_out is bit WIDTH of the unsigned sum A + B' + cin.
- STAGES = 1 degenerates to a single registered WIDTH-bit adder with latency 1.
- Reset (rst_n low, any time, asynchronously): all valid bits = 0, sum = 0, c_out = 0, ovf = 0, zero = 0. Data registers may also clear.
  - In-flight operations are discarded.
  - in_ready = 1 while in reset and after release, because out_valid = 0.
  - The first accepted operand after release has latency exactly STAGES.
- Simultaneous out transfer and in transfer in the same cycle is legal. At full occupancy this sustains 1/cycle.

Test Plan:
- WIDTH=16, SEG=4: a=16'h00FF, b=16'h0001, sub=0, c_in=0, out_ready=1 -> 4 cycles later out_valid=1, sum=16'h0100, c_out=0, ovf=0, zero=0. This proves carry crosses segment boundaries through the registers.
- a=16'hFFFF, b=16'h0001, sub=0 -> sum=16'h0000, c_out=1, zero=1, ovf=0. Then a=16'h7FFF, b=16'h0001 -> sum=16'h8000, ovf=1, c_out=0.
- Subtract: a=16'h0005, b=16'h0007, sub=1, c_in=1 (must be ignored) -> sum=16'hFFFE, c_out=0 (borrow), ovf=0. Then a=16'h8000, b=16'h0001, sub=1 -> sum=16'h7FFF, ovf=1, c_out=1.
- Back-to-back stream of 8 random ops with out_ready=1 -> 8 consecutive out_valid cycles, results in order, each matching the reference model A+B'+cin.
- Backpressure: stream 6 ops, drop out_ready for 3 cycles mid-stream -> in_ready=0 during the stall, outputs held stable, no ops lost or duplicated, order preserved.
- Assert rst_n=0 asynchronously with 3 ops in flight -> out_valid=0 and all flags 0 immediately, before any clock edge. After release, a single op (a=16'h1234, b=16'h1111) appears after exactly 4 cycles with sum=16'h2345.
